// File: rtl/vga_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_arb_pkg
//  Description : Shared constants and types for the VGA draw arbiter.
//                Screen geometry, coordinate/colour types, arbiter state
//                encoding and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_arb_pkg;

  // Visible raster of the vga_adapter; plots outside it are dropped.
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [7:0] xcoord_t;
  typedef logic [6:0] ycoord_t;
  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Width of an engine index; a single engine still needs one bit so that
  // the index registers never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_draw_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request bit at or after the pointer, wrapping modulo
//                NUM_REQ.
//  Ports       : req_i   - request vector
//                ptr_i   - highest-priority index for this pick
//                idx_o   - chosen index (0 when nothing is requested)
//                valid_o - at least one request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import vga_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // One extra bit so ptr + offset can exceed NUM_REQ-1 before the wrap.
  logic [IDX_W:0] w_cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      // Keep only the first hit in rotation order.
      if (!valid_o && req_i[w_cand[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_draw_arbiter
//  Description : Shares the vga_adapter plot port among NUM_REQ drawing
//                engines using the start/done handshake. Engines are granted
//                one at a time in round-robin order; the granted engine's
//                x/y/colour/plot are muxed to the adapter and the engine is
//                released one cycle after its done is seen.
//  Config      : define VGA_ARB_WATCHDOG_EN to add a per-grant watchdog that
//                forces a release after TIMEOUT_CYCLES grant cycles without
//                done and pulses timeout_o instead of fin_o.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                req_i               - level request per engine
//                eng_start_o         - one-hot grant / engine start
//                eng_done_i          - engine done flags
//                eng_x_i/y_i/colour_i- packed per-engine pixel (engine 0 LSBs)
//                eng_plot_i          - engine plot strobes
//                vga_x_o/y_o/colour_o/plot_o - to vga_adapter
//                fin_o               - one-cycle job-complete pulse per engine
//                busy_o              - arbiter not idle
//                timeout_o           - watchdog release pulse (optional)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_draw_arbiter
  import vga_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   eng_start_o,
  input  logic [NUM_REQ-1:0]   eng_done_i,
  input  logic [NUM_REQ*8-1:0] eng_x_i,
  input  logic [NUM_REQ*7-1:0] eng_y_i,
  input  logic [NUM_REQ*3-1:0] eng_colour_i,
  input  logic [NUM_REQ-1:0]   eng_plot_i,
  output logic [7:0]           vga_x_o,
  output logic [6:0]           vga_y_o,
  output logic [2:0]           vga_colour_o,
  output logic                 vga_plot_o,
  output logic [NUM_REQ-1:0]   fin_o,
  output logic                 busy_o
`ifdef VGA_ARB_WATCHDOG_EN
  ,
  output logic                 timeout_o
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_GRANT   = GRANT;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Elaboration-time guard on the supported configuration range; a bad
  // parameter set produces an obviously named empty scope.
  if (NUM_REQ < 1 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_param_range_violation
  end

  // --------------------------------------------------------------------------
  // Unpack the flat engine buses into per-engine arrays
  // --------------------------------------------------------------------------
  xcoord_t w_x_arr [NUM_REQ];
  ycoord_t w_y_arr [NUM_REQ];
  colour_t w_c_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_x_arr[gi] = eng_x_i[gi*8 +: 8];
    assign w_y_arr[gi] = eng_y_i[gi*7 +: 7];
    assign w_c_arr[gi] = eng_colour_i[gi*3 +: 3];
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [NUM_REQ-1:0] start_q, start_d;
  logic [NUM_REQ-1:0] fin_q,   fin_d;

`ifdef VGA_ARB_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (w_pick_idx),
    .valid_o (w_pick_valid)
  );

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    start_d = start_q;
    fin_d   = '0;
`ifdef VGA_ARB_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_pick_valid) begin
          grant_d = w_pick_idx;
          start_d = onehot(w_pick_idx);
          state_d = ST_GRANT;
`ifdef VGA_ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end
      end

      ST_GRANT: begin
        // A done already high on the first grant cycle is accepted; only the
        // granted engine's done is looked at.
        if (eng_done_i[grant_q]) begin
          state_d = ST_RELEASE;
          start_d = '0;
          fin_d   = onehot(grant_q);
        end
`ifdef VGA_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_LAST) begin
          // Hung engine: release without reporting a finished job.
          state_d   = ST_RELEASE;
          start_d   = '0;
          timeout_d = 1'b1;
        end
        else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end

      ST_RELEASE: begin
        // Always back through IDLE so start stays low for two cycles
        // before the same engine can be granted again.
        state_d = ST_IDLE;
        ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        start_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      start_q <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      start_q <= start_d;
      fin_q   <= fin_d;
    end
  end

`ifdef VGA_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic w_granted;

  assign w_granted   = (state_q == ST_GRANT);
  assign eng_start_o = start_q;
  assign fin_o       = fin_q;
  assign busy_o      = (state_q != ST_IDLE);

  // Pixel path is combinational from the granted engine; off-screen plots
  // are dropped so wrapped engine coordinates never reach the adapter.
  always_comb begin
    vga_x_o      = '0;
    vga_y_o      = '0;
    vga_colour_o = '0;
    vga_plot_o   = 1'b0;
    if (w_granted) begin
      vga_x_o      = w_x_arr[grant_q];
      vga_y_o      = w_y_arr[grant_q];
      vga_colour_o = w_c_arr[grant_q];
      vga_plot_o   = eng_plot_i[grant_q]
                     && (w_x_arr[grant_q] < xcoord_t'(SCREEN_W))
                     && (w_y_arr[grant_q] < ycoord_t'(SCREEN_H));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_draw_arbiter
//  Description : Self-checking bench for vga_draw_arbiter (NUM_REQ = 2).
//                Directed vector table, hand sequences for reset and
//                round-robin ordering, then randomized traffic against a
//                behavioural model. Watchdog section with VGA_ARB_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_draw_arbiter;

  localparam int N  = 2;
  localparam int TO = 20;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_r  = '0;
  logic [1:0]  done_r = '0;
  logic [1:0]  plot_r = '0;
  logic [15:0] x_r    = '0;
  logic [13:0] y_r    = '0;
  logic [5:0]  col_r  = '0;

  wire [1:0] eng_start;
  wire [1:0] fin;
  wire [7:0] vga_x;
  wire [6:0] vga_y;
  wire [2:0] vga_col;
  wire       vga_plot;
  wire       busy;
`ifdef VGA_ARB_WATCHDOG_EN
  wire       timeout;
`endif

  vga_draw_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_r),
    .eng_start_o  (eng_start),
    .eng_done_i   (done_r),
    .eng_x_i      (x_r),
    .eng_y_i      (y_r),
    .eng_colour_i (col_r),
    .eng_plot_i   (plot_r),
    .vga_x_o      (vga_x),
    .vga_y_o      (vga_y),
    .vga_colour_o (vga_col),
    .vga_plot_o   (vga_plot),
    .fin_o        (fin),
    .busy_o       (busy)
`ifdef VGA_ARB_WATCHDOG_EN
    ,
    .timeout_o    (timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic [1:0] es, input logic [1:0] ef, input logic eb,
                           input logic ep, input logic [7:0] ex, input logic [6:0] ey,
                           input logic [2:0] ec, input logic eto);
    chk("eng_start",  eng_start, es);
    chk("fin",        fin,       ef);
    chk("busy",       busy,      eb);
    chk("vga_plot",   vga_plot,  ep);
    chk("vga_x",      vga_x,     ex);
    chk("vga_y",      vga_y,     ey);
    chk("vga_colour", vga_col,   ec);
    chk("start_onehot", ($countones(eng_start) <= 1), 1);
`ifdef VGA_ARB_WATCHDOG_EN
    chk("timeout", timeout, eto);
`else
    if (eto) chk("timeout_unexpected", 1, 0);
`endif
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: who owns the port, who is being released, and the
  // rotation pointer. -1 means "nobody".
  // --------------------------------------------------------------------------
  int m_owner = -1;
  int m_rel   = -1;
  int m_ptr   = 0;
  int m_gcnt  = 0;
  bit m_rel_to = 1'b0;

  task automatic model_reset();
    m_owner = -1; m_rel = -1; m_ptr = 0; m_gcnt = 0; m_rel_to = 1'b0;
  endtask

  task automatic model_tick();
    if (m_rel >= 0) begin
      m_ptr    = (m_rel + 1) % N;
      m_rel    = -1;
      m_rel_to = 1'b0;
    end else if (m_owner >= 0) begin
      m_gcnt++;
      if (done_r[m_owner]) begin
        m_rel   = m_owner;
        m_owner = -1;
      end
`ifdef VGA_ARB_WATCHDOG_EN
      else if (m_gcnt >= TO) begin
        m_rel    = m_owner;
        m_rel_to = 1'b1;
        m_owner  = -1;
      end
`endif
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req_r[c]) m_owner = c;
      end
      m_gcnt = 0;
    end
  endtask

  // Engine emulation: done rises on the lat-th grant cycle.
  int e_cnt [N];
  int e_lat [N];
  bit lat_rand = 1'b0;

  task automatic step_model();
    logic [1:0] es, ef;
    logic       eb, ep, eto;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    es = '0; ef = '0; ep = 1'b0; ex = '0; ey = '0; ec = '0;
    if (m_owner >= 0) begin
      es = 2'(1 << m_owner);
      ex = x_r[m_owner*8 +: 8];
      ey = y_r[m_owner*7 +: 7];
      ec = col_r[m_owner*3 +: 3];
      ep = plot_r[m_owner] && (ex < 160) && (ey < 120);
    end
    if (m_rel >= 0 && !m_rel_to) ef = 2'(1 << m_rel);
    eto = (m_rel >= 0) && m_rel_to;
    eb  = (m_owner >= 0) || (m_rel >= 0);
    #1;
    check_all(es, ef, eb, ep, ex, ey, ec, eto);
  endtask

  task automatic tick();
    int prev;
    prev = m_owner;
    @(posedge clk);
    model_tick();
    for (int e = 0; e < N; e++) begin
      if (m_owner == e && prev == e) e_cnt[e]++;
      else e_cnt[e] = 0;
      if (lat_rand && m_owner == e && prev != e) e_lat[e] = $urandom_range(1, 6);
    end
    @(negedge clk);
  endtask

  task automatic drive_random(input bit noise);
    req_r = 2'($urandom_range(0, 3));
    for (int e = 0; e < N; e++) begin
      x_r[e*8 +: 8]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 170))
                                                   : 8'($urandom_range(0, 255));
      y_r[e*7 +: 7]  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127))
                                                   : 7'($urandom_range(0, 127));
      col_r[e*3 +: 3] = 3'($urandom_range(0, 7));
      plot_r[e]      = 1'($urandom_range(0, 1));
      if (m_owner == e) done_r[e] = (e_cnt[e] >= e_lat[e] - 1);
      else              done_r[e] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic cyc(input logic [1:0] rq, input logic [1:0] dn, input logic [1:0] pl);
    req_r = rq; done_r = dn; plot_r = pl;
    step_model();
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table (engine 1 pixel fixed at (20,30) colour 5)
  // --------------------------------------------------------------------------
  typedef struct {
    logic [1:0] req, done, plot;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] c0;
    logic [1:0] es, ef;
    logic       eb, ep;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
  } vec_t;

  function automatic vec_t mk(logic [1:0] req, logic [1:0] done, logic [1:0] plot,
                              logic [7:0] x0, logic [6:0] y0, logic [2:0] c0,
                              logic [1:0] es, logic [1:0] ef, logic eb, logic ep,
                              logic [7:0] ex, logic [6:0] ey, logic [2:0] ec);
    vec_t v;
    v.req = req; v.done = done; v.plot = plot; v.x0 = x0; v.y0 = y0; v.c0 = c0;
    v.es = es; v.ef = ef; v.eb = eb; v.ep = ep; v.ex = ex; v.ey = ey; v.ec = ec;
    return v;
  endfunction

  vec_t tbl [11];
  int   exp_order [4];

  initial begin
    int n_gr;
    int n_to;
    logic [1:0] prev_start;

    tbl[0]  = mk(2'b01, 2'b00, 2'b10,  80,  60, 3'd2, 2'b00, 2'b00, 0, 0,   0,   0, 0);
    tbl[1]  = mk(2'b01, 2'b00, 2'b11,  80,  60, 3'd2, 2'b01, 2'b00, 1, 1,  80,  60, 2);
    tbl[2]  = mk(2'b00, 2'b10, 2'b11, 160,  60, 3'd2, 2'b01, 2'b00, 1, 0, 160,  60, 2);
    tbl[3]  = mk(2'b00, 2'b10, 2'b11, 159, 119, 3'd3, 2'b01, 2'b00, 1, 1, 159, 119, 3);
    tbl[4]  = mk(2'b00, 2'b01, 2'b11, 100, 120, 3'd7, 2'b01, 2'b00, 1, 0, 100, 120, 7);
    tbl[5]  = mk(2'b00, 2'b01, 2'b11, 100,  50, 3'd7, 2'b00, 2'b01, 1, 0,   0,   0, 0);
    tbl[6]  = mk(2'b00, 2'b00, 2'b00,   0,   0, 3'd0, 2'b00, 2'b00, 0, 0,   0,   0, 0);
    tbl[7]  = mk(2'b10, 2'b10, 2'b00,   0,   0, 3'd0, 2'b00, 2'b00, 0, 0,   0,   0, 0);
    tbl[8]  = mk(2'b10, 2'b10, 2'b10,   0,   0, 3'd0, 2'b10, 2'b00, 1, 1,  20,  30, 5);
    tbl[9]  = mk(2'b00, 2'b00, 2'b00,   0,   0, 3'd0, 2'b00, 2'b10, 1, 0,   0,   0, 0);
    tbl[10] = mk(2'b00, 2'b00, 2'b00,   0,   0, 3'd0, 2'b00, 2'b00, 0, 0,   0,   0, 0);
    exp_order = '{0, 1, 0, 1};

    for (int e = 0; e < N; e++) begin e_cnt[e] = 0; e_lat[e] = 1; end
    model_reset();

    // Reset state, with a request already pending
    req_r = 2'b01;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      req_r  = tbl[i].req;
      done_r = tbl[i].done;
      plot_r = tbl[i].plot;
      x_r    = {8'd20, tbl[i].x0};
      y_r    = {7'd30, tbl[i].y0};
      col_r  = {3'd5,  tbl[i].c0};
      #1;
      check_all(tbl[i].es, tbl[i].ef, tbl[i].eb, tbl[i].ep,
                tbl[i].ex, tbl[i].ey, tbl[i].ec, 1'b0);
      tick();
    end

    // Move the pointer to engine 1, grant engine 1, then reset mid-grant
    x_r = {8'd40, 8'd80}; y_r = {7'd40, 7'd60}; col_r = {3'd1, 3'd2};
    cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b10, 2'b00, 2'b10);
    req_r = 2'b00; done_r = 2'b00; plot_r = 2'b10;
    step_model();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_eng_start", eng_start, 0);
    chk("rst_vga_plot",  vga_plot,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_vga_x",     vga_x,     0);
    model_reset();
    for (int e = 0; e < N; e++) e_cnt[e] = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both engines request continuously, five-cycle jobs
    e_lat[0] = 5; e_lat[1] = 5;
    lat_rand = 1'b0;
    n_gr = 0;
    prev_start = 2'b00;
    for (int c = 0; c < 28; c++) begin
      drive_random(1'b0);
      req_r = 2'b11;
      step_model();
      if (eng_start != 2'b00 && prev_start == 2'b00) begin
        if (n_gr < 4) chk("grant_order", eng_start[1] ? 1 : 0, exp_order[n_gr]);
        n_gr++;
      end
      prev_start = eng_start;
      tick();
    end
    chk("grant_count", n_gr, 4);
    for (int c = 0; c < 3; c++) cyc(2'b00, 2'b00, 2'b00);

    // Randomized traffic with done noise from the non-granted engine
    lat_rand = 1'b1;
    for (int c = 0; c < 400; c++) begin
      drive_random(1'b1);
      step_model();
      tick();
    end

`ifdef VGA_ARB_WATCHDOG_EN
    // Drain, then a hung engine 0 while engine 1 waits its turn
    lat_rand = 1'b0;
    e_lat[0] = 3; e_lat[1] = 3;
    for (int c = 0; c < 10; c++) begin
      drive_random(1'b0);
      req_r = 2'b00;
      step_model();
      tick();
    end
    e_lat[0] = 100000; e_lat[1] = 3;
    n_to = 0;
    for (int c = 0; c < 40; c++) begin
      drive_random(1'b0);
      req_r = (c < 24) ? 2'b11 : 2'b00;
      step_model();
      if (timeout === 1'b1) n_to++;
      tick();
    end
    chk("timeout_count", n_to, 1);
`else
    n_to = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
